fe_buf_pingpong: RTL and testbench

//  Ping-pong feature buffer directly upstream of the scheduler. Four banks, one per input-channel lane, each holding
//  one SCH_COL_NUM-wide pixel row per address. The loader fills one half of the buffer while the scheduler reads the

---
 rtl/fe_buf_pingpong.sv | 111 +++++++++++
 tb/tb_fe_buf_pingpong.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/fe_buf_pingpong.sv
// Ping-pong feature buffer feeding the scheduler: four lane banks, two halves,
// the loader fills one half while the scheduler reads the other.
module fe_buf_pingpong #(
    parameter int IFM_WIDTH   = 8,
    parameter int SCH_COL_NUM = 40,
    parameter int ADDR_WIDTH  = 10
) (
    input  logic                             clk,
    input  logic                             rstn,
    input  logic                             tile_switch,
    input  logic [3:0]                       ld_wr_en,
    input  logic [ADDR_WIDTH-1:0]            ld_wr_addr,
    input  logic [SCH_COL_NUM*IFM_WIDTH-1:0] ld_wr_data,
    input  logic                             ld_wr_last,
    output logic                             buf_rdy,
    output logic                             sw_err,
    input  logic [3:0]                       fe_olp_buf_rd_en,
    input  logic [ADDR_WIDTH-1:0]            fe_buf_rd_addr_0,
    input  logic [ADDR_WIDTH-1:0]            fe_buf_rd_addr_1,
    input  logic [ADDR_WIDTH-1:0]            fe_buf_rd_addr_2,
    input  logic [ADDR_WIDTH-1:0]            fe_buf_rd_addr_3,
    output logic [SCH_COL_NUM*IFM_WIDTH-1:0] fe_rd_data_0,
    output logic [SCH_COL_NUM*IFM_WIDTH-1:0] fe_rd_data_1,
    output logic [SCH_COL_NUM*IFM_WIDTH-1:0] fe_rd_data_2,
    output logic [SCH_COL_NUM*IFM_WIDTH-1:0] fe_rd_data_3,
    output logic [3:0]                       fe_rd_vld
);

    localparam int DW    = SCH_COL_NUM * IFM_WIDTH;
    localparam int DEPTH = 1 << ADDR_WIDTH;

    logic [DW-1:0] mem [2][4][DEPTH];

    logic           rd_sel_q, rd_sel_d;
    logic [1:0]     full_q, full_d;
    logic           sw_err_q, sw_err_d;
    logic           wr_half;
    logic [DW-1:0]  rd_data_q [4];
    logic [3:0]     rd_vld_q;
    logic [ADDR_WIDTH-1:0] rd_addr [4];

    assign wr_half = ~rd_sel_q;
    assign buf_rdy = full_q[wr_half];
    assign sw_err  = sw_err_q;

    assign rd_addr[0] = fe_buf_rd_addr_0;
    assign rd_addr[1] = fe_buf_rd_addr_1;
    assign rd_addr[2] = fe_buf_rd_addr_2;
    assign rd_addr[3] = fe_buf_rd_addr_3;

    assign fe_rd_data_0 = rd_data_q[0];
    assign fe_rd_data_1 = rd_data_q[1];
    assign fe_rd_data_2 = rd_data_q[2];
    assign fe_rd_data_3 = rd_data_q[3];
    assign fe_rd_vld    = rd_vld_q;

    // A switch is judged against the registered buf_rdy, so a last write
    // and a switch landing in the same cycle drops the switch.
    always_comb begin
        rd_sel_d = rd_sel_q;
        full_d   = full_q;
        sw_err_d = sw_err_q;
        if (ld_wr_last && (|ld_wr_en))
            full_d[wr_half] = 1'b1;
        if (tile_switch) begin
            if (buf_rdy) begin
                rd_sel_d         = ~rd_sel_q;
                full_d[rd_sel_q] = 1'b0;
            end else begin
                sw_err_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rd_sel_q <= 1'b0;
            full_q   <= 2'b00;
            sw_err_q <= 1'b0;
        end else begin
            rd_sel_q <= rd_sel_d;
            full_q   <= full_d;
            sw_err_q <= sw_err_d;
        end
    end

    // Storage is never reset; the write half is always the one not being read.
    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (ld_wr_en[i])
                mem[wr_half][i][ld_wr_addr] <= ld_wr_data;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rd_vld_q <= 4'b0000;
            for (int i = 0; i < 4; i++)
                rd_data_q[i] <= '0;
        end else begin
            rd_vld_q <= fe_olp_buf_rd_en;
            for (int i = 0; i < 4; i++) begin
                if (fe_olp_buf_rd_en[3-i])
                    rd_data_q[i] <= mem[rd_sel_q][i][rd_addr[i]];
                else
                    rd_data_q[i] <= '0;
            end
        end
    end

endmodule

// File: tb/tb_fe_buf_pingpong.sv
// Directed bench for fe_buf_pingpong: fill, switch, race, overlap and
// read-enable gating with hand-computed expectations.
module tb_fe_buf_pingpong;

    localparam int DW = 320;
    localparam int AW = 10;

    logic          clk = 1'b0;
    logic          rstn;
    logic          tile_switch;
    logic [3:0]    ld_wr_en;
    logic [AW-1:0] ld_wr_addr;
    logic [DW-1:0] ld_wr_data;
    logic          ld_wr_last;
    logic          buf_rdy;
    logic          sw_err;
    logic [3:0]    rd_en;
    logic [AW-1:0] ra0, ra1, ra2, ra3;
    logic [DW-1:0] rd0, rd1, rd2, rd3;
    logic [3:0]    rd_vld;

    int errors = 0;
    int checks = 0;

    fe_buf_pingpong dut (
        .clk              (clk),
        .rstn             (rstn),
        .tile_switch      (tile_switch),
        .ld_wr_en         (ld_wr_en),
        .ld_wr_addr       (ld_wr_addr),
        .ld_wr_data       (ld_wr_data),
        .ld_wr_last       (ld_wr_last),
        .buf_rdy          (buf_rdy),
        .sw_err           (sw_err),
        .fe_olp_buf_rd_en (rd_en),
        .fe_buf_rd_addr_0 (ra0),
        .fe_buf_rd_addr_1 (ra1),
        .fe_buf_rd_addr_2 (ra2),
        .fe_buf_rd_addr_3 (ra3),
        .fe_rd_data_0     (rd0),
        .fe_rd_data_1     (rd1),
        .fe_rd_data_2     (rd2),
        .fe_rd_data_3     (rd3),
        .fe_rd_vld        (rd_vld)
    );

    always #5 clk = ~clk;

    function automatic logic [DW-1:0] rep(input logic [7:0] b);
        return {40{b}};
    endfunction

    task automatic chk(input string tag, input logic [DW-1:0] obs,
                       input logic [DW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_rd(input logic [3:0] en, input logic [AW-1:0] a);
        rd_en = en;
        ra0 = a;
        ra1 = a;
        ra2 = a;
        ra3 = a;
    endtask

    initial begin
        rstn        = 1'b0;
        tile_switch = 1'b0;
        ld_wr_en    = 4'h0;
        ld_wr_addr  = '0;
        ld_wr_data  = '0;
        ld_wr_last  = 1'b0;
        set_rd(4'h0, '0);

        // 1: reset
        tick();
        tick();
        chk("rst_buf_rdy", DW'(buf_rdy), '0);
        chk("rst_sw_err", DW'(sw_err), '0);
        chk("rst_vld", DW'(rd_vld), '0);
        chk("rst_data0", rd0, '0);
        chk("rst_data3", rd3, '0);
        rstn = 1'b1;
        set_rd(4'hF, '0);
        tick();
        chk("rd_vld_all", DW'(rd_vld), DW'(4'hF));
        set_rd(4'h0, '0);
        tick();
        chk("rd_vld_off", DW'(rd_vld), '0);

        // 2: fill half 1, bank by bank
        for (int b = 0; b < 4; b++) begin
            for (int r = 0; r < 10; r++) begin
                ld_wr_en   = 4'(1 << b);
                ld_wr_addr = AW'(r);
                ld_wr_data = rep(8'(b + 1));
                ld_wr_last = (b == 3 && r == 9);
                if (b == 3 && r == 9)
                    chk("rdy_before_last", DW'(buf_rdy), '0);
                tick();
            end
        end
        ld_wr_en   = 4'h0;
        ld_wr_last = 1'b0;
        chk("rdy_after_last", DW'(buf_rdy), DW'(1'b1));
        tile_switch = 1'b1;
        tick();
        tile_switch = 1'b0;
        chk("sw_ok_rdy", DW'(buf_rdy), '0);
        chk("sw_ok_err", DW'(sw_err), '0);
        set_rd(4'hF, 10'd5);
        tick();
        set_rd(4'h0, '0);
        chk("rd5_b0", rd0, rep(8'h01));
        chk("rd5_b1", rd1, rep(8'h02));
        chk("rd5_b2", rd2, rep(8'h03));
        chk("rd5_b3", rd3, rep(8'h04));

        // 3: early switch dropped
        tile_switch = 1'b1;
        tick();
        tile_switch = 1'b0;
        chk("early_err", DW'(sw_err), DW'(1'b1));
        set_rd(4'hF, 10'd5);
        tick();
        set_rd(4'h0, '0);
        chk("early_b0", rd0, rep(8'h01));
        chk("early_b3", rd3, rep(8'h04));

        // 4/5: fill half 0 with AA while reading half 1; race on last row
        for (int r = 0; r < 10; r++) begin
            ld_wr_en    = 4'hF;
            ld_wr_addr  = AW'(r);
            ld_wr_data  = rep(8'hAA);
            ld_wr_last  = (r == 9);
            tile_switch = (r == 9);
            set_rd(4'hF, AW'(r));
            tick();
            chk("ovl_b0", rd0, rep(8'h01));
            chk("ovl_b2", rd2, rep(8'h03));
        end
        ld_wr_en    = 4'h0;
        ld_wr_last  = 1'b0;
        tile_switch = 1'b0;
        set_rd(4'h0, '0);
        chk("race_err", DW'(sw_err), DW'(1'b1));
        chk("race_rdy", DW'(buf_rdy), DW'(1'b1));

        tile_switch = 1'b1;
        set_rd(4'hF, 10'd3);
        tick();
        tile_switch = 1'b0;
        chk("swcyc_b2", rd2, rep(8'h03));
        chk("swcyc_b1", rd1, rep(8'h02));
        chk("sw2_rdy", DW'(buf_rdy), '0);
        for (int r = 0; r < 10; r++) begin
            set_rd(4'hF, AW'(r));
            tick();
            chk("new_b1", rd1, rep(8'hAA));
            chk("new_b3", rd3, rep(8'hAA));
        end

        // 6: enable gating
        set_rd(4'b1010, 10'd4);
        tick();
        set_rd(4'h0, '0);
        chk("gate_vld", DW'(rd_vld), DW'(4'b1010));
        chk("gate_b0", rd0, rep(8'hAA));
        chk("gate_b1", rd1, '0);
        chk("gate_b2", rd2, rep(8'hAA));
        chk("gate_b3", rd3, '0);

        // sticky error only clears on reset
        chk("err_sticky", DW'(sw_err), DW'(1'b1));
        #2;
        rstn = 1'b0;
        #1;
        chk("rst2_err", DW'(sw_err), '0);
        chk("rst2_rdy", DW'(buf_rdy), '0);
        chk("rst2_vld", DW'(rd_vld), '0);
        tick();
        rstn = 1'b1;
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
